// File: rtl/mem_router_pkg.sv
// rtl/mem_router_pkg.sv - shared memory-port types, selects, states and address map defaults
//
// Purpose: definitions shared by the router, its decoder and any future master port.
//   mem_in_type  : mem_valid, mem_instr, mem_addr[63:0], mem_wdata[63:0], mem_wstrb[7:0]
//   mem_out_type : mem_ready, mem_error, mem_rdata[63:0]
//   sel_e        : which slave a request targets (SEL_NONE when unmapped or refused)
//   state_e      : router state (IDLE, BUSY, ERR)
package mem_router_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [63:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_PER,
    SEL_RAM
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_e;

  localparam logic [63:0] DEF_ROM_BASE = 64'h0000_0000_0000_0000;
  localparam logic [63:0] DEF_ROM_SIZE = 64'h0000_0000_0000_0100;
  localparam logic [63:0] DEF_PER_BASE = 64'h0000_0000_0100_0000;
  localparam logic [63:0] DEF_PER_SIZE = 64'h0000_0000_0010_0000;
  localparam logic [63:0] DEF_RAM_BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_RAM_SIZE = 64'h0000_0000_1000_0000;

  // Sizes are powers of two, so masking off the in-region offset leaves the base on a hit.
  function automatic logic region_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] size);
    return (addr & ~(size - 64'd1)) == base;
  endfunction

endpackage

// File: rtl/mem_decode.sv
// rtl/mem_decode.sv - combinational address decoder for one master port
//
// Purpose: maps a request address and write strobes onto a slave select, or flags an error.
// Ports:
//   addr  in  [63:0]  request address
//   wstrb in  [7:0]   write strobes (non-zero means write)
//   sel   out sel_e   target slave, SEL_NONE when err is set
//   err   out 1       unmapped address or write to ROM
module mem_decode
  import mem_router_pkg::*;
#(
  parameter logic [63:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [63:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [63:0] PER_BASE = DEF_PER_BASE,
  parameter logic [63:0] PER_SIZE = DEF_PER_SIZE,
  parameter logic [63:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [63:0] RAM_SIZE = DEF_RAM_SIZE
) (
  input  logic [63:0] addr,
  input  logic [7:0]  wstrb,
  output sel_e        sel,
  output logic        err
);

  always_comb begin
    sel = SEL_NONE;
    err = 1'b0;
    if (region_hit(addr, ROM_BASE, ROM_SIZE)) begin
      if (wstrb != 8'h00) begin
        err = 1'b1;
      end else begin
        sel = SEL_ROM;
      end
    end else if (region_hit(addr, PER_BASE, PER_SIZE)) begin
      sel = SEL_PER;
    end else if (region_hit(addr, RAM_BASE, RAM_SIZE)) begin
      sel = SEL_RAM;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/mem_router.sv
// rtl/mem_router.sv - single-master decoder and response mux for ROM, peripherals and RAM
//
// Purpose: forwards one request at a time to the addressed slave and returns its response,
// or answers locally with an error for unmapped addresses, ROM writes and slave timeouts.
// Ports:
//   clock    in   1             system clock, rising edge
//   reset    in   1             asynchronous active-low reset
//   mstr_in  in   mem_in_type   master request
//   mstr_out out  mem_out_type  master response (one-cycle mem_ready pulse per request)
//   rom_in   out  mem_in_type   ROM request        rom_out in mem_out_type ROM response
//   per_in   out  mem_in_type   peripheral request per_out in mem_out_type peripheral response
//   ram_in   out  mem_in_type   RAM request        ram_out in mem_out_type RAM response
module mem_router
  import mem_router_pkg::*;
#(
  parameter logic [63:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [63:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [63:0] PER_BASE = DEF_PER_BASE,
  parameter logic [63:0] PER_SIZE = DEF_PER_SIZE,
  parameter logic [63:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [63:0] RAM_SIZE = DEF_RAM_SIZE,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  mstr_in,
  output mem_out_type mstr_out,
  output mem_in_type  rom_in,
  input  mem_out_type rom_out,
  output mem_in_type  per_in,
  input  mem_out_type per_out,
  output mem_in_type  ram_in,
  input  mem_out_type ram_out
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state, state_nxt;
  sel_e        sel, sel_nxt;
  logic [15:0] cnt, cnt_nxt;
  mem_in_type  req_q, req_nxt;

  sel_e        dec_sel;
  logic        dec_err;
  mem_in_type  fwd;
  sel_e        fwd_sel;
  mem_out_type sel_rsp;

  mem_decode #(
    .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE),
    .PER_BASE(PER_BASE), .PER_SIZE(PER_SIZE),
    .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE)
  ) u_decode (
    .addr (mstr_in.mem_addr),
    .wstrb(mstr_in.mem_wstrb),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= SEL_NONE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      req_q <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    req_nxt   = req_q;
    fwd       = '0;
    fwd_sel   = SEL_NONE;
    mstr_out  = '0;

    // Only the slave we are waiting on may answer; everyone else is ignored.
    sel_rsp = '0;
    case (sel)
      SEL_ROM: sel_rsp = rom_out;
      SEL_PER: sel_rsp = per_out;
      SEL_RAM: sel_rsp = ram_out;
      default: sel_rsp = '0;
    endcase

    case (state)
      IDLE: begin
        if (mstr_in.mem_valid) begin
          req_nxt           = mstr_in;
          req_nxt.mem_valid = 1'b0;
          cnt_nxt           = '0;
          if (dec_err) begin
            state_nxt = ERR;
            sel_nxt   = SEL_NONE;
          end else begin
            state_nxt = BUSY;
            sel_nxt   = dec_sel;
            fwd       = mstr_in;
            fwd_sel   = dec_sel;
          end
        end
      end
      BUSY: begin
        // Hold the request on the slave bus with valid dropped so the slave sees one strobe.
        fwd     = req_q;
        fwd_sel = sel;
        cnt_nxt = cnt + 16'd1;
        if (sel_rsp.mem_ready) begin
          mstr_out  = sel_rsp;
          state_nxt = IDLE;
          sel_nxt   = SEL_NONE;
        end else if (cnt == CNT_LAST) begin
          mstr_out.mem_ready = 1'b1;
          mstr_out.mem_error = 1'b1;
          state_nxt          = IDLE;
          sel_nxt            = SEL_NONE;
        end
      end
      ERR: begin
        mstr_out.mem_ready = 1'b1;
        mstr_out.mem_error = 1'b1;
        state_nxt          = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = SEL_NONE;
      end
    endcase

    // The IDLE pass-through path is combinational from mstr_in, so gate it while reset is low.
    if (!reset) begin
      mstr_out = '0;
      fwd_sel  = SEL_NONE;
    end
  end

  assign rom_in = (fwd_sel == SEL_ROM) ? fwd : '0;
  assign per_in = (fwd_sel == SEL_PER) ? fwd : '0;
  assign ram_in = (fwd_sel == SEL_RAM) ? fwd : '0;

endmodule

// File: tb/tb_mem_router.sv
// tb/tb_mem_router.sv - self-checking bench for mem_router with slave models and a reference model
module tb_mem_router;
  import mem_router_pkg::*;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  mstr_in = '0;
  mem_out_type mstr_out;
  mem_in_type  rom_in, per_in, ram_in;
  mem_out_type rom_out = '0, per_out = '0, ram_out = '0;

  int checks = 0;
  int failures = 0;

  int ram_delay = 1;
  int per_delay = 1;
  int ram_cnt = 0;
  int per_cnt = 0;
  logic [63:0] ram_a, per_a;
  logic [63:0] rom_mem [32];

  mem_router #(.TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset   (reset),
    .mstr_in (mstr_in),
    .mstr_out(mstr_out),
    .rom_in  (rom_in),
    .rom_out (rom_out),
    .per_in  (per_in),
    .per_out (per_out),
    .ram_in  (ram_in),
    .ram_out (ram_out)
  );

  always #5 clock = ~clock;

  // Slave models: ROM answers one cycle after valid; RAM/PER answer ram_delay/per_delay cycles
  // after valid. A new valid cancels any response still pending from an earlier request.
  function automatic mem_out_type ram_rsp(input logic [63:0] a);
    return '{mem_ready: 1'b1, mem_error: 1'b0, mem_rdata: {a[31:0], 32'hCAFE_0000}};
  endfunction

  function automatic mem_out_type per_rsp(input logic [63:0] a);
    return '{mem_ready: 1'b1, mem_error: a[3], mem_rdata: ~a};
  endfunction

  always @(posedge clock) begin
    rom_out <= '0;
    if (rom_in.mem_valid)
      rom_out <= '{mem_ready: 1'b1, mem_error: 1'b0, mem_rdata: rom_mem[rom_in.mem_addr[7:3]]};
  end

  always @(posedge clock) begin
    ram_out <= '0;
    if (ram_in.mem_valid) begin
      ram_cnt <= 0;
      if (ram_delay == 1) ram_out <= ram_rsp(ram_in.mem_addr);
      else begin
        ram_cnt <= ram_delay - 1;
        ram_a   <= ram_in.mem_addr;
      end
    end else if (ram_cnt > 0) begin
      ram_cnt <= ram_cnt - 1;
      if (ram_cnt == 1) ram_out <= ram_rsp(ram_a);
    end
  end

  always @(posedge clock) begin
    per_out <= '0;
    if (per_in.mem_valid) begin
      per_cnt <= 0;
      if (per_delay == 1) per_out <= per_rsp(per_in.mem_addr);
      else begin
        per_cnt <= per_delay - 1;
        per_a   <= per_in.mem_addr;
      end
    end else if (per_cnt > 0) begin
      per_cnt <= per_cnt - 1;
      if (per_cnt == 1) per_out <= per_rsp(per_a);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] valid_vec(input int s);
    case (s)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic mem_in_type slv_in(input int s);
    case (s)
      1:       return rom_in;
      2:       return per_in;
      3:       return ram_in;
      default: return '0;
    endcase
  endfunction

  // Issue one request and follow it to its response, checking the slave buses every cycle.
  task automatic run_req(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb, input logic instr, input int exp_lat,
                         input logic exp_err, input logic [63:0] exp_data, input int exp_slv);
    int lat;
    logic got;
    mem_in_type s;
    @(negedge clock);
    mstr_in = '{mem_valid: 1'b1, mem_instr: instr, mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb};
    #1;
    chk({tag, " req_valids"}, {61'd0, rom_in.mem_valid, per_in.mem_valid, ram_in.mem_valid},
        {61'd0, valid_vec(exp_slv)});
    chk({tag, " req_cycle_ready"}, {63'd0, mstr_out.mem_ready}, 64'd0);
    if (exp_slv != 0) begin
      s = slv_in(exp_slv);
      chk({tag, " pass_addr"}, s.mem_addr, addr);
      chk({tag, " pass_wdata"}, s.mem_wdata, wdata);
      chk({tag, " pass_attr"}, {55'd0, s.mem_instr, s.mem_wstrb}, {55'd0, instr, wstrb});
    end
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clock);
      mstr_in = '0;
      lat++;
      #1;
      if ({rom_in.mem_valid, per_in.mem_valid, ram_in.mem_valid} != 3'b000)
        chk({tag, " busy_valids"}, {61'd0, rom_in.mem_valid, per_in.mem_valid, ram_in.mem_valid}, 64'd0);
      if (mstr_out.mem_ready) begin
        got = 1'b1;
      end else begin
        if (mstr_out.mem_rdata != 64'd0) chk({tag, " idle_rdata"}, mstr_out.mem_rdata, 64'd0);
        if (exp_slv != 0) begin
          s = slv_in(exp_slv);
          if (s.mem_addr != addr || s.mem_wdata != wdata || s.mem_wstrb != wstrb)
            chk({tag, " busy_hold_addr"}, s.mem_addr, addr);
        end
      end
    end
    chk({tag, " got_ready"}, {63'd0, got}, 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " error"}, {63'd0, mstr_out.mem_error}, {63'd0, exp_err});
    chk({tag, " rdata"}, mstr_out.mem_rdata, exp_data);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        instr;
    int          ram_d;
    int          per_d;
    int          lat;
    logic        err;
    logic [63:0] rdata;
    int          slv;
  } vec_t;

  vec_t vecs [14];

  // Reference model: regions as half-open address ranges, response rules from the slave delays.
  task automatic predict(input logic [63:0] addr, input logic [7:0] wstrb, input int rd, input int pd,
                         output int lat, output logic err, output logic [63:0] data, output int slv);
    int d;
    lat = 1; err = 1'b1; data = 64'd0; slv = 0; d = 0;
    if (addr < 64'h100) begin
      if (wstrb == 8'h00) begin
        slv = 1; err = 1'b0; data = rom_mem[addr / 8];
      end
      return;
    end else if (addr >= 64'h0100_0000 && addr < 64'h0110_0000) begin
      slv = 2; d = pd; err = addr[3]; data = ~addr;
    end else if (addr >= 64'h8000_0000 && addr < 64'h9000_0000) begin
      slv = 3; d = rd; err = 1'b0; data = {addr[31:0], 32'hCAFE_0000};
    end else begin
      return;
    end
    if (d <= TMO) lat = d;
    else begin
      lat = TMO; err = 1'b1; data = 64'd0;
    end
  endtask

  initial begin
    int lat, slv, kind, cnt_ready, late_seen;
    logic err;
    logic [63:0] data, addr;
    logic [7:0] ws;
    logic [63:0] unm [6];

    for (int i = 0; i < 32; i++) rom_mem[i] = 64'hA5A5_0000_0000_0000 + 64'(i);

    vecs[0]  = '{64'h10,          64'h0,                  8'h00, 1'b1, 1, 1,  1, 1'b0, 64'hA5A5_0000_0000_0002, 1};
    vecs[1]  = '{64'h8000_0040,   64'hDEADBEEF_0000_1234, 8'hFF, 1'b0, 5, 1,  5, 1'b0, 64'h8000_0040_CAFE_0000, 3};
    vecs[2]  = '{64'h4000_0000,   64'h0,                  8'h00, 1'b0, 1, 1,  1, 1'b1, 64'h0,                   0};
    vecs[3]  = '{64'h8,           64'h1234,               8'h0F, 1'b0, 1, 1,  1, 1'b1, 64'h0,                   0};
    vecs[4]  = '{64'h0100_0010,   64'h0,                  8'h00, 1'b0, 1, 3,  3, 1'b0, 64'hFFFF_FFFF_FEFF_FFEF, 2};
    vecs[5]  = '{64'h0100_0008,   64'h77,                 8'h03, 1'b0, 1, 2,  2, 1'b1, 64'hFFFF_FFFF_FEFF_FFF7, 2};
    vecs[6]  = '{64'h8FFF_FFF8,   64'h0,                  8'h00, 1'b0, 8, 1,  8, 1'b0, 64'h8FFF_FFF8_CAFE_0000, 3};
    vecs[7]  = '{64'h8000_0018,   64'h0,                  8'h00, 1'b0, 9, 1,  8, 1'b1, 64'h0,                   3};
    vecs[8]  = '{64'h9000_0000,   64'h0,                  8'h00, 1'b0, 1, 1,  1, 1'b1, 64'h0,                   0};
    vecs[9]  = '{64'h100,         64'h0,                  8'h00, 1'b1, 1, 1,  1, 1'b1, 64'h0,                   0};
    vecs[10] = '{64'hF8,          64'h0,                  8'h00, 1'b1, 1, 1,  1, 1'b0, 64'hA5A5_0000_0000_001F, 1};
    vecs[11] = '{64'h010F_FFF8,   64'h0,                  8'h00, 1'b0, 1, 1,  1, 1'b1, 64'hFFFF_FFFF_FEF0_0007, 2};
    vecs[12] = '{64'h8000_0000,   64'h55,                 8'h01, 1'b0, 1, 1,  1, 1'b0, 64'h8000_0000_CAFE_0000, 3};
    vecs[13] = '{64'h00FF_FFF8,   64'h0,                  8'h00, 1'b0, 1, 1,  1, 1'b1, 64'h0,                   0};

    // Reset state, with a live ROM request on the master side that must not leak through.
    mstr_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 64'h10, mem_wdata: 64'h0, mem_wstrb: 8'h00};
    repeat (2) @(negedge clock);
    #1;
    chk("reset mstr_out", {63'd0, mstr_out != '0}, 64'd0);
    chk("reset rom_in", {63'd0, rom_in != '0}, 64'd0);
    chk("reset slaves", {62'd0, per_in != '0, ram_in != '0}, 64'd0);
    mstr_in = '0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      ram_delay = vecs[i].ram_d;
      per_delay = vecs[i].per_d;
      run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
              vecs[i].lat, vecs[i].err, vecs[i].rdata, vecs[i].slv);
    end

    // Peripheral timeout, then its late response arrives while idle and must be dropped.
    per_delay = TMO + 3;
    run_req("per_timeout", 64'h0100_0020, 64'h0, 8'h00, 1'b0, TMO, 1'b1, 64'h0, 2);
    cnt_ready = 0;
    late_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1;
      if (mstr_out.mem_ready) cnt_ready++;
      if (per_out.mem_ready) late_seen++;
    end
    chk("late_per_ready_seen", 64'(late_seen), 64'd1);
    chk("late_per_no_response", 64'(cnt_ready), 64'd0);

    // Back-to-back ROM reads with valid re-asserted in the response cycle.
    @(negedge clock);
    mstr_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 64'h0, mem_wdata: 64'h0, mem_wstrb: 8'h00};
    #1;
    chk("b2b first_valid", {63'd0, rom_in.mem_valid}, 64'd1);
    @(negedge clock);
    mstr_in.mem_addr = 64'h8;
    #1;
    chk("b2b first_ready", {63'd0, mstr_out.mem_ready}, 64'd1);
    chk("b2b first_rdata", mstr_out.mem_rdata, 64'hA5A5_0000_0000_0000);
    chk("b2b no_accept_in_ready", {63'd0, rom_in.mem_valid}, 64'd0);
    @(negedge clock);
    #1;
    chk("b2b second_valid", {63'd0, rom_in.mem_valid}, 64'd1);
    chk("b2b second_addr", rom_in.mem_addr, 64'h8);
    chk("b2b gap_ready", {63'd0, mstr_out.mem_ready}, 64'd0);
    @(negedge clock);
    mstr_in = '0;
    #1;
    chk("b2b second_ready", {63'd0, mstr_out.mem_ready}, 64'd1);
    chk("b2b second_rdata", mstr_out.mem_rdata, 64'hA5A5_0000_0000_0001);

    // Reset in the middle of a slow RAM access.
    ram_delay = 20;
    @(negedge clock);
    mstr_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 64'h8000_0100, mem_wdata: 64'h99, mem_wstrb: 8'hF0};
    @(negedge clock);
    mstr_in = '0;
    #1;
    chk("midrst busy_ram_addr", ram_in.mem_addr, 64'h8000_0100);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst mstr_out", {63'd0, mstr_out != '0}, 64'd0);
    chk("midrst ram_in", {63'd0, ram_in != '0}, 64'd0);
    chk("midrst other_in", {62'd0, rom_in != '0, per_in != '0}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cnt_ready = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      #1;
      if (mstr_out.mem_ready) cnt_ready++;
    end
    chk("midrst no_response", 64'(cnt_ready), 64'd0);
    run_req("after_rst", 64'h18, 64'h0, 8'h00, 1'b0, 1, 1'b0, 64'hA5A5_0000_0000_0003, 1);

    // Randomized traffic against the reference model.
    unm[0] = 64'h4000_0000; unm[1] = 64'h9000_0000; unm[2] = 64'h100;
    unm[3] = 64'h0110_0000; unm[4] = 64'hFFFF_FFFF_FFFF_FFF8; unm[5] = 64'h7FFF_FFF8;
    for (int t = 0; t < 150; t++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0:       addr = {56'd0, 3'($urandom_range(0, 7)), 5'd0} | {56'd0, 5'($urandom_range(0, 31)), 3'd0};
        1:       addr = 64'h0100_0000 + {44'd0, 17'($urandom), 3'd0};
        2:       addr = 64'h8000_0000 + {36'd0, 25'($urandom), 3'd0};
        3:       addr = unm[$urandom_range(0, 5)];
        default: addr = {$urandom, $urandom};
      endcase
      if (kind == 0) addr = addr & 64'hF8;
      ws = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      ram_delay = int'($urandom_range(1, 11));
      per_delay = int'($urandom_range(1, 11));
      predict(addr, ws, ram_delay, per_delay, lat, err, data, slv);
      run_req($sformatf("rnd%0d", t), addr, {$urandom, $urandom}, ws, 1'($urandom),
              lat, err, data, slv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Single-master address decoder and response multiplexer. Sits directly upstream of the boot ROM, main RAM and the peripheral block.
- Accepts a mem_in_type request from the core-side memory port and forwards it to exactly one slave. Returns that slave's mem_out_type response.
- Generates error responses locally for unmapped addresses, ROM writes and slave timeouts.
- Allows one outstanding transaction at a time.

Parameters:
- ROM_BASE, 64'h0000_0000, ROM region base address
- ROM_SIZE, 64'h0000_0100, ROM region size in bytes (power of two)
- PER_BASE, 64'h0100_0000, peripheral region base address
- PER_SIZE, 64'h0010_0000, peripheral region size in bytes (power of two)
- RAM_BASE, 64'h8000_0000, RAM region base address
- RAM_SIZE, 64'h1000_0000, RAM region size in bytes (power of two)
- TIMEOUT, 256, cycles to wait for a slave mem_ready before returning an error (2..65535)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mstr_in  in  mem_in_type  master request (mem_valid, mem_instr, mem_addr[63:0], mem_wdata[63:0], mem_wstrb[7:0])
- mstr_out  out  mem_out_type  master response (mem_ready, mem_error, mem_rdata[63:0])
- rom_in  out  mem_in_type  request to ROM
- rom_out  in  mem_out_type  ROM response
- per_in  out  mem_in_type  request to peripherals
- per_out  in  mem_out_type  peripheral response
- ram_in  out  mem_in_type  request to RAM
- ram_out  in  mem_out_type  RAM response

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, sel=NONE, timeout counter=0, request register cleared.
  - All mstr_out and slave *_in fields are 0.
- Decode: region hit when (mem_addr & ~(SIZE-1)) == BASE. Regions must not overlap. Any other address is unmapped.
- Write: a request is a write when mem_wstrb != 0.
- IDLE:
  - When mstr_in.mem_valid==1, the request is accepted in that cycle.
  - The selected slave's mem_valid is driven combinationally high for exactly this one cycle. The master's addr/wdata/wstrb/instr pass through in the same cycle and are captured into the request register.
  - Mapped request, not a ROM write: go to BUSY with sel set to the slave and counter=0.
  - Unmapped address or write to ROM: nothing is forwarded. Go to ERR.
- BUSY:
  - Selected slave's *_in carries the registered request with mem_valid=0.
  - Counter increments every cycle.
  - When the selected slave's mem_ready==1, mstr_out takes that slave's rdata/error/ready combinationally (zero added latency). Return to IDLE.
  - If the counter reaches TIMEOUT-1 without mem_ready, drive mstr_out.mem_ready=1 and mem_error=1 with rdata=0 for one cycle, then return to IDLE.
  - Slave ready and timeout in the same cycle: the slave response wins.
- ERR: drive mstr_out.mem_ready=1, mem_error=1, mem_rdata=0 for one cycle, then return to IDLE.
- mstr_out.mem_ready is a single-cycle pulse per accepted request. It is 0 in all other cycles.
- mstr_out.mem_rdata is 0 whenever mem_ready is 0.
- Master protocol: mstr_in.mem_valid asserted during BUSY or ERR is ignored (not queued). The master holds off until it sees mem_ready.
- Back-to-back: a new request may be accepted in the first IDLE cycle after the response cycle. The router never accepts a request in the response cycle itself.
- Unselected slaves, and any slave mem_ready while IDLE (e.g. a late response after a timeout), are ignored and discarded.
- Read latency against the ROM (1-cycle registered slave): request in cycle N, mstr_out.mem_ready in cycle N+1.
- Reset asserted mid-transaction: return to IDLE immediately. No response is produced for the aborted request.

Decomposition:
- Shared package:
  - region-select enum (SEL_NONE, SEL_ROM, SEL_PER, SEL_RAM);
  - router state enum (IDLE, BUSY, ERR);
  - default base/size constants (placed beside the existing mem_in_type/mem_out_type definitions).
- One natural sub-module: mem_decode. It is purely combinational, maps address plus wstrb to select and error flags, and is reused by any future second master.

Test Plan:
- Read from ROM at addr 0x10: mem_valid pulse in cycle N → rom_in.mem_valid=1 in cycle N only; mstr_out.mem_ready=1 in N+1 with rdata=ROM word 2; mem_error=0.
- Write to 0x8000_0040, wdata 0xDEADBEEF_0000_1234, wstrb 0xFF; RAM model responds after 5 cycles → ram_in fields stable through BUSY; single ready pulse aligned with RAM ready.
- Access to 0x4000_0000 (unmapped) and a write with wstrb=0x0F to 0x0000_0008 (ROM) → no slave valid; mem_ready=1, mem_error=1, rdata=0 exactly one cycle after the request.
- Peripheral model that never responds, TIMEOUT=8 → error pulse 8 cycles after acceptance; a later per_out.mem_ready in IDLE produces no master response.
- Back-to-back ROM reads at 0x00, 0x08 with master re-asserting valid in the ready cycle → second request accepted one cycle after the first response; valid in the ready cycle is ignored.
- Assert reset (0) in the middle of a BUSY RAM access → all outputs 0 at once; no response pulse; after release, a ROM read completes normally.
